// File: rtl/hex_bank_scheduler.sv
// Round-robin request/grant scheduler sharing the six-digit HEX bank between two display requesters.
// Optional build macro HEX_SCHED_GAP_DASH_EN shows dashes during the changeover gap instead of blanks.
module hex_bank_scheduler #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [1:0]  REQ,
    input  logic [41:0] SEG0,
    input  logic [41:0] SEG1,
    output logic [1:0]  GNT,
    output logic        BUSY,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_MAX  = CW'(GAP_CYCLES);
    localparam logic [41:0] BLANK = {42{1'b1}};
`ifdef HEX_SCHED_GAP_DASH_EN
    localparam logic [41:0] GAP_PAT = {6{7'b0111111}};
`else
    localparam logic [41:0] GAP_PAT = {42{1'b1}};
`endif

    generate
        if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_param
            $error("hex_bank_scheduler: HOLD_CYCLES and GAP_CYCLES must both be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] gap_cnt;
    logic          last;
    logic [41:0]   hex_bus;

    logic win_valid;
    logic win;
    logic owner;
    logic release_now;

    // Winner of a fresh arbitration; on a tie the requester that did not win last time goes.
    always_comb begin
        win_valid = |REQ;
        win       = (REQ == 2'b11) ? ~last : REQ[1];
    end

    // Voluntary release takes priority over preemption when both happen in the same cycle.
    always_comb begin
        owner       = (state == OWN1);
        release_now = !REQ[owner] || (REQ[~owner] && (hold_cnt == HOLD_MAX));
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= IDLE;
            GNT      <= 2'b00;
            BUSY     <= 1'b0;
            hex_bus  <= BLANK;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            last     <= 1'b1;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (state == GAP && gap_cnt != GAP_MAX) begin
                        gap_cnt <= gap_cnt + CW'(1);
                    end else if (win_valid) begin
                        state    <= win ? OWN1 : OWN0;
                        GNT      <= win ? 2'b10 : 2'b01;
                        BUSY     <= 1'b1;
                        hex_bus  <= BLANK;
                        hold_cnt <= CW'(1);
                        last     <= win;
                    end else begin
                        state   <= IDLE;
                        GNT     <= 2'b00;
                        BUSY    <= 1'b0;
                        hex_bus <= BLANK;
                    end
                end
                OWN0, OWN1: begin
                    if (release_now) begin
                        state   <= GAP;
                        GNT     <= 2'b00;
                        gap_cnt <= CW'(1);
                        hex_bus <= GAP_PAT;
                    end else begin
                        hex_bus <= owner ? SEG1 : SEG0;
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    GNT   <= 2'b00;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    assign HEX0 = hex_bus[6:0];
    assign HEX1 = hex_bus[13:7];
    assign HEX2 = hex_bus[20:14];
    assign HEX3 = hex_bus[27:21];
    assign HEX4 = hex_bus[34:28];
    assign HEX5 = hex_bus[41:35];

endmodule

// File: tb/tb_hex_bank_scheduler.sv
// Directed self-checking bench for hex_bank_scheduler (default parameters).
// Expected gap pattern follows HEX_SCHED_GAP_DASH_EN when the bench is built with it.
module tb_hex_bank_scheduler;

    logic        CLK;
    logic        RESET_N;
    logic [1:0]  REQ;
    logic [41:0] SEG0;
    logic [41:0] SEG1;
    logic [1:0]  GNT;
    logic        BUSY;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int vectors;
    int miscompares;

    localparam logic [41:0] BLANK = {42{1'b1}};
`ifdef HEX_SCHED_GAP_DASH_EN
    localparam logic [41:0] GAP_PAT = {6{7'b0111111}};
`else
    localparam logic [41:0] GAP_PAT = {42{1'b1}};
`endif
    localparam logic [41:0] PAT0 = {7'h12, 7'h02, 7'h19, 7'h30, 7'h24, 7'h79};
    localparam logic [41:0] PAT1 = {6{7'h40}};

    hex_bank_scheduler #(.HOLD_CYCLES(8), .GAP_CYCLES(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .SEG0(SEG0), .SEG1(SEG1),
        .GNT(GNT), .BUSY(BUSY),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [41:0] hexAll();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    // One rising edge with REQ driven beforehand; outputs are then stable for sampling.
    task automatic applyStimulus(input logic [1:0] req);
        REQ = req;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RESET_N     = 1'b0;
        SEG0        = PAT0;
        SEG1        = PAT1;
        REQ         = 2'b11;

        for (int i = 0; i < 3; i++) applyStimulus(2'b11);
        checkOutput("reset_gnt",  64'(GNT),      64'(2'b00));
        checkOutput("reset_busy", 64'(BUSY),     64'(1'b0));
        checkOutput("reset_hex",  64'(hexAll()), 64'(BLANK));

        RESET_N = 1'b1;
        applyStimulus(2'b11);
        checkOutput("first_grant",     64'(GNT),      64'(2'b01));
        checkOutput("first_busy",      64'(BUSY),     64'(1'b1));
        checkOutput("first_hex_blank", 64'(hexAll()), 64'(BLANK));

        // Requester 1 waits while requester 0 runs out its hold time.
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(2'b11);
            checkOutput($sformatf("hold_gnt%0d", i), 64'(GNT), 64'(2'b01));
            if (i == 2) checkOutput("own0_hex", 64'(hexAll()), 64'(PAT0));
        end
        applyStimulus(2'b11);
        checkOutput("preempt_gnt",  64'(GNT),      64'(2'b00));
        checkOutput("preempt_busy", 64'(BUSY),     64'(1'b1));
        checkOutput("preempt_gap1", 64'(hexAll()), 64'(GAP_PAT));
        applyStimulus(2'b11);
        checkOutput("gap2_gnt", 64'(GNT),      64'(2'b00));
        checkOutput("gap2_hex", 64'(hexAll()), 64'(GAP_PAT));
        applyStimulus(2'b11);
        checkOutput("after_gap_gnt", 64'(GNT),      64'(2'b10));
        checkOutput("after_gap_hex", 64'(hexAll()), 64'(BLANK));

        // Lone owner is never preempted.
        applyStimulus(2'b10);
        checkOutput("own1_hex", 64'(hexAll()), 64'(PAT1));
        for (int i = 0; i < 50; i++) begin
            applyStimulus(2'b10);
            checkOutput("single_hold", 64'(GNT), 64'(2'b10));
        end

        applyStimulus(2'b00);
        checkOutput("release_gnt",  64'(GNT),  64'(2'b00));
        checkOutput("release_busy", 64'(BUSY), 64'(1'b1));
        applyStimulus(2'b00);
        applyStimulus(2'b00);
        checkOutput("idle_busy", 64'(BUSY),     64'(1'b0));
        checkOutput("idle_hex",  64'(hexAll()), 64'(BLANK));

        // Both requesters release and reassert together: grants alternate.
        for (int r = 0; r < 4; r++) begin
            applyStimulus(2'b11);
            checkOutput($sformatf("rr_grant%0d", r), 64'(GNT), (r % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            if (r < 3) begin
                for (int k = 0; k < 3; k++) applyStimulus(2'b00);
                checkOutput($sformatf("rr_idle%0d", r), 64'(BUSY), 64'(1'b0));
            end
        end

        // Reset while requester 1 owns the bank.
        RESET_N = 1'b0;
        applyStimulus(2'b11);
        checkOutput("midreset_gnt",  64'(GNT),      64'(2'b00));
        checkOutput("midreset_busy", 64'(BUSY),     64'(1'b0));
        checkOutput("midreset_hex",  64'(hexAll()), 64'(BLANK));
        RESET_N = 1'b1;
        applyStimulus(2'b11);
        checkOutput("postreset_gnt", 64'(GNT), 64'(2'b01));

        // Owner drops while the other asserts: release, gap, then the other is served.
        applyStimulus(2'b10);
        checkOutput("swap_gnt",  64'(GNT),      64'(2'b00));
        checkOutput("swap_gap1", 64'(hexAll()), 64'(GAP_PAT));
        applyStimulus(2'b10);
        checkOutput("swap_gap2", 64'(hexAll()), 64'(GAP_PAT));
        applyStimulus(2'b10);
        checkOutput("swap_grant", 64'(GNT),      64'(2'b10));
        checkOutput("swap_hex",   64'(hexAll()), 64'(BLANK));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
